// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush, data-memory wait FSM with timeout.
// Optional performance counters are built only when PIPE_HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
    parameter logic [15:0] MAX_WAIT = 16'd255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_id_rs1_addr,
    input  logic [4:0]  i_id_rs2_addr,
    input  logic        i_id_rs1_used,
    input  logic        i_id_rs2_used,
    input  logic [4:0]  i_ex_rd_addr,
    input  logic        i_ex_rd_wren,
    input  logic        i_ex_is_load,
    input  logic        i_ex_pc_sel,
    input  logic        i_mem_req,
    input  logic        i_mem_ack,
    output logic        o_stall_pc,
    output logic        o_stall_if_id,
    output logic        o_stall_id_ex,
    output logic        o_stall_ex_mem,
    output logic        o_stall_mem_wb,
    output logic        o_flush_if_id,
    output logic        o_flush_id_ex,
    output logic        o_flush_mem_wb,
    output logic [1:0]  o_state,
    output logic        o_mem_timeout,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_redirects
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;

    logic load_use;
    logic mem_busy;
    logic redirect_evt;

    assign load_use = i_ex_is_load & i_ex_rd_wren & (i_ex_rd_addr != 5'd0) &
                      ((i_id_rs1_used & (i_id_rs1_addr == i_ex_rd_addr)) |
                       (i_id_rs2_used & (i_id_rs2_addr == i_ex_rd_addr)));
    assign mem_busy = i_mem_req & ~i_mem_ack;

    // Control outputs follow the event priority: timeout, memory busy, redirect, load-use.
    // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        o_stall_pc     = 1'b0;
        o_stall_if_id  = 1'b0;
        o_stall_id_ex  = 1'b0;
        o_stall_ex_mem = 1'b0;
        o_stall_mem_wb = 1'b0;
        o_flush_if_id  = 1'b0;
        o_flush_id_ex  = 1'b0;
        o_flush_mem_wb = 1'b0;
        redirect_evt   = 1'b0;
        if (!i_reset) begin
            if (state_q == ST_TIMEOUT) begin
                {o_stall_pc, o_stall_if_id, o_stall_id_ex, o_stall_ex_mem, o_stall_mem_wb} = 5'b11111;
            end else if (mem_busy) begin
                {o_stall_pc, o_stall_if_id, o_stall_id_ex, o_stall_ex_mem, o_stall_mem_wb} = 5'b11111;
                o_flush_mem_wb = 1'b1;
            end else if (i_ex_pc_sel) begin
                o_flush_if_id = 1'b1;
                o_flush_id_ex = 1'b1;
                redirect_evt  = 1'b1;
            end else if (load_use) begin
                o_stall_pc    = 1'b1;
                o_stall_if_id = 1'b1;
                o_flush_id_ex = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 16'd0;
                end
            end
            ST_WAIT: begin
                // An ack arriving on the final allowed cycle still completes normally.
                if (!i_mem_req || i_mem_ack) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == MAX_WAIT - 16'd1) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ST_TIMEOUT: state_d = ST_TIMEOUT;
            default:    state_d = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 16'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_state       = state_q;
    assign o_mem_timeout = timeout_q & ~i_reset;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] redirects_q, redirects_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, o_stall_pc};
        redirects_d    = redirects_q + {31'd0, redirect_evt};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cycles_q <= 32'd0;
            redirects_q    <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            redirects_q    <= redirects_d;
        end
    end

    assign o_stall_cycles = stall_cycles_q;
    assign o_redirects    = redirects_q;
`else
    logic unused_perf;
    assign unused_perf    = redirect_evt;
    assign o_stall_cycles = 32'h0;
    assign o_redirects    = 32'h0;
`endif

endmodule
